neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Serial neuron body that sits directly downstream of the ternary synapse multiplier. Each cycle it consumes one 2-bit signed synapse product (−1/0/+1) and sums a frame of up to `N_INPUTS` products in a saturating accumulator. At end of frame it compares the sum with a threshold and presents a one-bit spike plus the sum on a valid/ready output. Fractal-NN layers chain these outputs as the `x` inputs of the next synapse stage.

## Interface
- `N_INPUTS`, default 16: maximum products per frame; frame is force-closed on the `N_INPUTS`-th beat.
- `ACC_W`, default 5: signed accumulator/sum width; range −2^(ACC_W−1) .. 2^(ACC_W−1)−1.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_y`/`in_last` valid this cycle.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_y` input 2: signed synapse product; 2'b01=+1, 2'b11=−1, 2'b00=0, 2'b10 treated as 0.
- `in_last` input 1: beat closes the frame.
- `threshold` input ACC_W: signed firing threshold; sampled when the frame closes.
- `out_valid` output 1: result held on `out_spike`/`out_sum`.
- `out_ready` input 1: downstream consumes the result.
- `out_spike` output 1: 1 iff final sum ≥ `threshold` (signed compare).
- `out_sum` output ACC_W: final signed sum of the frame.

## Operation
- States: ACCUM (collecting beats), HOLD (result pending). Reset → ACCUM.
- Beat accepted when `in_valid && in_ready`; `in_ready` = (state == ACCUM).
- Accepted beat: acc ← sat(acc + in_y); beat counter +1.
- Frame closes on accepted beat with `in_last`=1 or counter == `N_INPUTS`−1. On close: `out_sum` ← sat(acc + in_y), `out_spike` ← (that value ≥ `threshold`), counter ← 0, state → HOLD.
- HOLD: `out_valid`=1, outputs stable; `out_valid && out_ready` → ACCUM, and acc ← frame-start value (see Configuration).
- Saturation: clamp at max/min of `ACC_W`; no wrap-around. Once clamped, later opposite-sign beats move away from the clamp normally.
- 2'b10 on `in_y` adds 0 but still counts as a beat.
- Beats arriving after a forced close while in HOLD are stalled (`in_ready`=0); next accepted beat starts a new frame.

## Timing
- Reset values: `in_ready`=1 (in ACCUM after release), `out_valid`=0, `out_spike`=0, `out_sum`=0, acc=0, counter=0.
- Latency: `out_valid` rises the cycle after the closing beat is accepted.
- Output handshake completes in the cycle `out_valid && out_ready`; `in_ready` is 1 the following cycle. Minimum frame period = beats + 1 cycle.
- `in_ready` depends only on state (no combinational path from `out_ready`).
- `in_valid` while `in_ready`=0: beat not taken; upstream must hold it.
- Reset asserted mid-frame or in HOLD: immediate abort, all outputs to reset values, partial sum discarded.
- Single-beat frame (`in_last` on first beat) is legal: `out_sum` = that product.

## Configuration
- `NEURON_LEAK_EN` defined: leaky integrate-and-fire. On output handshake acc ← (frame sum if `out_spike`=0, else 0) arithmetically shifted right by 1 (`>>>1`, round toward −∞). Residual carries into the next frame.
- Not defined: acc ← 0 at every frame start; frames independent.

## Test plan
- Reset then 4 beats +1,+1,−1,+1 with `in_last` on 4th, `threshold`=2, `out_ready`=1 → `out_valid` 1 cycle after 4th beat, `out_sum`=2, `out_spike`=1.
- 16 beats of +1, no `in_last`, ACC_W=5 → forced close on 16th beat, `out_sum`=15 (saturated), spike for `threshold`=15.
- 16 beats of −1 then threshold 0 → `out_sum`=−16, `out_spike`=0; 2'b10 beats mixed in change nothing but count.
- `out_ready`=0 for 5 cycles in HOLD with `in_valid`=1 → `in_ready`=0, outputs stable, no beats lost; release → next frame starts clean.
- Assert `rst` after 3 beats of +1 → all outputs 0 immediately; new 1-beat frame +1 → `out_sum`=1.
- `NEURON_LEAK_EN`: frame sum 3, `threshold`=5 (no spike), then 1-beat frame 0 → `out_sum`=1; with spike instead, second `out_sum`=0.

Source files
------------

// File: rtl/neuron_accumulator.sv
// Serial saturating accumulator neuron: sums a frame of ternary products, thresholds at frame close.
// Optional build macro NEURON_LEAK_EN carries a halved residual of the previous frame into the next.
module neuron_accumulator #(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_y,
    input  logic             in_last,
    input  logic [ACC_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_spike,
    output logic [ACC_W-1:0] out_sum
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              y_val;
    logic [ACC_W:0]          sum_ext;
    logic signed [ACC_W-1:0] sum_sat;
    logic signed [ACC_W-1:0] start_val;
    logic                    take;
    logic                    close;

    assign in_ready = (state == ACCUM);
    assign take     = in_valid && in_ready;
    assign close    = take && (in_last || (cnt == LAST_CNT));

    // 2'b10 is not a legal product and contributes nothing
    always_comb begin
        y_val = 2'b00;
        case (in_y)
            2'b01:   y_val = 2'b01;
            2'b11:   y_val = 2'b11;
            default: y_val = 2'b00;
        endcase
    end

    assign sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W-1){y_val[1]}}, y_val};
    assign sum_sat = (sum_ext[ACC_W] != sum_ext[ACC_W-1])
                     ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX)
                     : sum_ext[ACC_W-1:0];

`ifdef NEURON_LEAK_EN
    // A spiking neuron resets; otherwise half the potential leaks into the next frame
    assign start_val = out_spike ? '0 : ($signed(out_sum) >>> 1);
`else
    assign start_val = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_spike <= 1'b0;
            out_sum   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        out_sum   <= sum_sat;
                        out_spike <= (sum_sat >= $signed(threshold));
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= HOLD;
                    end else if (take) begin
                        acc <= sum_sat;
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= start_val;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator (default and NEURON_LEAK_EN builds).
module tb_neuron_accumulator;

    localparam int ACC_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_y = 2'b00;
    logic             in_last = 1'b0;
    logic [ACC_W-1:0] threshold = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_spike;
    logic [ACC_W-1:0] out_sum;

    int tests  = 0;
    int failed = 0;

    neuron_accumulator #(.N_INPUTS(16), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_last   (in_last),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_spike (out_spike),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat presented for exactly one cycle; the block must be ready for it
    task automatic send(input logic [1:0] y, input logic last);
        chk("in_ready_before_beat", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_y     = y;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_y     = 2'b00;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int sum, input int spike);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_sum"},   $signed(out_sum), sum);
        chk({tag, "_spike"}, 32'(out_spike), spike);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 0);
        chk({tag, "_ready_back"}, 32'(in_ready), 1);
    endtask

    initial begin
        // Reset values
        step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", $signed(out_sum), 0);
        chk("rst_out_spike", 32'(out_spike), 0);
        rst = 1'b0;
        step();

        // F1: +1 +1 -1 +1, last on 4th, threshold 2
        threshold = 5'sd2;
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        send(2'b11, 1'b0);
        chk("f1_not_closed", 32'(out_valid), 0);
        send(2'b01, 1'b1);
        check_result("f1", 2, 1);
        handshake("f1");

        // F2: 16 x +1, forced close, saturates at 15
        threshold = 5'sd15;
        for (int i = 0; i < 15; i++) send(2'b01, 1'b0);
        chk("f2_no_early_close", 32'(out_valid), 0);
        send(2'b01, 1'b0);
        check_result("f2", 15, 1);

        // HOLD with out_ready low and a pending beat: stalled, outputs stable
        in_valid = 1'b1;
        in_y     = 2'b01;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_sum", $signed(out_sum), 15);
        end
        handshake("f2");
        // F3: the held beat is taken now as a clean single-beat frame
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_y     = 2'b00;
        check_result("f3", 1, 0);
        handshake("f3");

        // F4: 16 x -1, threshold 0
        threshold = 5'sd0;
        for (int i = 0; i < 16; i++) send(2'b11, 1'b0);
        check_result("f4", -16, 0);
        handshake("f4");

        // F5: 2'b10 every 4th beat counts toward the forced close but adds nothing
        for (int i = 0; i < 15; i++) send((i % 4 == 0) ? 2'b10 : 2'b11, 1'b0);
        chk("f5_no_early_close", 32'(out_valid), 0);
        send(2'b11, 1'b0);
`ifdef NEURON_LEAK_EN
        check_result("f5", -16, 0);
`else
        check_result("f5", -12, 0);
`endif
        handshake("f5");

        // F6: reset after 3 beats discards the partial frame immediately
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_sum", $signed(out_sum), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        step();
        rst = 1'b0;
        step();
        threshold = 5'sd1;
        send(2'b01, 1'b1);
        check_result("f7", 1, 1);
        handshake("f7");

        // F8/F9: sum 3 below threshold 5, then single zero beat
        threshold = 5'sd5;
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        send(2'b01, 1'b1);
        check_result("f8", 3, 0);
        handshake("f8");
        send(2'b00, 1'b1);
`ifdef NEURON_LEAK_EN
        check_result("f9", 1, 0);
`else
        check_result("f9", 0, 0);
`endif
        handshake("f9");

        // F10/F11: same sum but spiking, so nothing carries over
        threshold = 5'sd2;
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        send(2'b01, 1'b1);
        check_result("f10", 3, 1);
        handshake("f10");
        send(2'b00, 1'b1);
        check_result("f11", 0, 0);
        handshake("f11");

        // Negative threshold: sum -1 still fires against -2
        threshold = 5'b11110;
        send(2'b11, 1'b1);
        check_result("f12", -1, 1);
        handshake("f12");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
